mux_21: RTL and testbench

Two-input, one-output selector with a registered copy of its output and a saturating select-toggle counter. Its combinational path is a plain 2:1 multiplexer. The clocked side gives downstream logic a glitch-free, one-cycle-delayed output and a cheap activity monitor on the select line. It is used as a leaf cell wherever a data source must be switched between two producers.

---
 rtl/mux_21.sv | 61 ++++++
 tb/tb_mux_21.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux_21.sv
// 2:1 mux with a registered output copy and an optional saturating select-toggle counter.
// Define MUX21_SWCNT_EN to build the counter; otherwise sw_cnt is tied to zero.
module mux_21 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] c,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] c_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] sw_cnt
);

    logic [WIDTH-1:0] c_d;
    logic             sel_d;

    // A continuous ?: keeps the X-merge behaviour when sel is unknown.
    assign c = sel ? b : a;

    always_comb begin
        c_d   = c;
        sel_d = sel;
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q   <= '0;
            sel_q <= 1'b0;
        end else begin
            c_q   <= c_d;
            sel_q <= sel_d;
        end
    end

`ifdef MUX21_SWCNT_EN
    logic [CNT_W-1:0] sw_cnt_q;
    logic [CNT_W-1:0] sw_cnt_d;

    always_comb begin
        // NOTE: default assignment first so no latch is inferred.
        sw_cnt_d = sw_cnt_q;
        if ((sel != sel_q) && (sw_cnt_q != {CNT_W{1'b1}}))
            sw_cnt_d = sw_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) sw_cnt_q <= '0;
        else        sw_cnt_q <= sw_cnt_d;
    end

    assign sw_cnt = sw_cnt_q;
`else
    assign sw_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_21.sv
// Self-checking bench for mux_21: a behavioural model compared every cycle, plus
// directed literal checks; a second instance (WIDTH=4, CNT_W=2) covers saturation.
module tb_mux_21;

`ifdef MUX21_SWCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b, sel;
    logic       c, c_q, sel_q;
    logic [7:0] sw_cnt;

    logic [3:0] a2, b2, c2, c2_q;
    logic       sel2_q;
    logic [1:0] sw_cnt2;

    assign a2 = {4{a}} ^ 4'b0101;
    assign b2 = {4{b}} ^ 4'b0011;

    mux_21 dut (
        .a(a), .b(b), .sel(sel), .c(c), .clk(clk), .rst_n(rst_n),
        .c_q(c_q), .sel_q(sel_q), .sw_cnt(sw_cnt)
    );

    mux_21 #(.WIDTH(4), .CNT_W(2)) dut2 (
        .a(a2), .b(b2), .sel(sel), .c(c2), .clk(clk), .rst_n(rst_n),
        .c_q(c2_q), .sel_q(sel2_q), .sw_cnt(sw_cnt2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pick(input logic [3:0] x, input logic [3:0] y, input logic s);
        if (s == 1'b1) return y;
        return x;
    endfunction

    // Behavioural model: what each register must hold after every edge.
    bit         m_valid = 1'b0;
    logic       m_c_q, m_sel_q;
    logic [3:0] m_c2_q;
    int         m_toggles, m_cnt, m_cnt2;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid   = 1'b1;
            m_c_q     = 1'b0;
            m_c2_q    = 4'h0;
            m_sel_q   = 1'b0;
            m_toggles = 0;
        end else begin
            if (sel !== m_sel_q) m_toggles++;
            m_sel_q = sel;
            m_c_q   = pick({3'b0, a}, {3'b0, b}, sel) != 0;
            m_c2_q  = pick(a2, b2, sel);
        end
        m_cnt  = CNT_EN ? ((m_toggles > 255) ? 255 : m_toggles) : 0;
        m_cnt2 = CNT_EN ? ((m_toggles > 3) ? 3 : m_toggles) : 0;
    end

    // Inputs only change at negedge+2 or at odd offsets, so negedge sampling is race-free.
    always @(negedge clk) begin
        check("cmp_c",  {31'b0, c}, {28'b0, pick({3'b0, a}, {3'b0, b}, sel)});
        check("cmp_c2", {28'b0, c2}, {28'b0, pick(a2, b2, sel)});
        if (m_valid) begin
            check("cmp_c_q",     {31'b0, c_q},     {31'b0, m_c_q});
            check("cmp_sel_q",   {31'b0, sel_q},   {31'b0, m_sel_q});
            check("cmp_sw_cnt",  {24'b0, sw_cnt},  m_cnt);
            check("cmp_c2_q",    {28'b0, c2_q},    {28'b0, m_c2_q});
            check("cmp_sel2_q",  {31'b0, sel2_q},  {31'b0, m_sel_q});
            check("cmp_sw_cnt2", {30'b0, sw_cnt2}, m_cnt2);
        end
    end

    task automatic drive(input logic rn, input logic va, input logic vb, input logic vs);
        @(negedge clk);
        #2;
        rst_n = rn; a = va; b = vb; sel = vs;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] sweep [6];
    logic       sweep_c [6];
    logic [2:0] v;
    logic [3:0] pat;

    initial begin
        rst_n = 1'b0; a = 1'b0; b = 1'b0; sel = 1'b0;
        sweep = '{3'b000, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};
        sweep_c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Combinational truth sweep, (a,b,sel), 10 ns apart, offset away from edges.
        #3;
        for (int i = 0; i < 6; i++) begin
            v = sweep[i];
            a = v[2]; b = v[1]; sel = v[0];
            #1;
            check("sweep_c", {31'b0, c}, {31'b0, sweep_c[i]});
            #9;
        end

        // Reset held for two edges with a=1, sel=0.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            after_edge();
            check("rst_c",      {31'b0, c},     32'd1);
            check("rst_c_q",    {31'b0, c_q},   32'd0);
            check("rst_sel_q",  {31'b0, sel_q}, 32'd0);
            check("rst_sw_cnt", {24'b0, sw_cnt}, 32'd0);
        end

        // Latency: release with a=1,b=0,sel=0, then switch sel to 1.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        after_edge();
        check("lat_c_q_1", {31'b0, c_q}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        check("lat_c_now", {31'b0, c}, 32'd0);
        check("lat_c_q_hold", {31'b0, c_q}, 32'd1);
        after_edge();
        check("lat_c_q_0", {31'b0, c_q}, 32'd0);
        check("lat_sw_cnt", {24'b0, sw_cnt}, CNT_EN ? 32'd1 : 32'd0);

        // Toggle counting: fresh reset, then sel = 0,1,1,0,1 -> three toggles.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        after_edge();
        pat = 4'b0110;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, pat[i]);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        after_edge();
        check("tog_sw_cnt",  {24'b0, sw_cnt},  CNT_EN ? 32'd3 : 32'd0);
        check("tog_sw_cnt2", {30'b0, sw_cnt2}, CNT_EN ? 32'd3 : 32'd0);

        // Six more toggles: CNT_W=2 instance saturates at 3, default one reaches 9.
        for (int i = 0; i < 6; i++) drive(1'b1, i[0], ~i[0], i[0]);
        after_edge();
        check("sat_sw_cnt2", {30'b0, sw_cnt2}, CNT_EN ? 32'd3 : 32'd0);
        check("sat_sw_cnt",  {24'b0, sw_cnt},  CNT_EN ? 32'd9 : 32'd0);

        // Reset mid-count with sel=1, then one edge with sel still 1.
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        after_edge();
        check("mid_sw_cnt2", {30'b0, sw_cnt2}, 32'd0);
        check("mid_sel2_q",  {31'b0, sel2_q},  32'd0);
        check("mid_sw_cnt",  {24'b0, sw_cnt},  32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        after_edge();
        check("mid_next_cnt2", {30'b0, sw_cnt2}, CNT_EN ? 32'd1 : 32'd0);
        check("mid_next_cnt",  {24'b0, sw_cnt},  CNT_EN ? 32'd1 : 32'd0);
        check("mid_c2_q",      {28'b0, c2_q},    32'hC);

        // Mixed data traffic, checked by the per-cycle compare only.
        for (int i = 0; i < 16; i++) drive(1'b1, i[1], i[2], i[0] ^ i[3]);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
